// File: rtl/lcd_rgb565_out.sv
// lcd_rgb565_out: reduces 24-bit generator RGB to RGB565 (optional 4x4 Bayer dither),
// delays DE/HS/VS to stay aligned, and measures line/frame geometry with sticky errors.
module lcd_rgb565_out #(
  parameter int unsigned PIX_W     = 480,
  parameter int unsigned PIX_H     = 272,
  parameter bit          DITHER_EN = 1'b1,
  parameter logic        VS_ACT    = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [23:0] in_rgb,
  input  logic        err_clr,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [15:0] out_rgb,
  output logic [11:0] line_px,
  output logic [11:0] frame_ln,
  output logic [15:0] frame_cnt,
  output logic        err_line,
  output logic        err_frame
);

  localparam int unsigned CW = 12;
  localparam int unsigned SW = 9;
  localparam int unsigned FW = 16;
  localparam int unsigned RW = 6;
  localparam int unsigned GW = 7;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic [CW-1:0] pcnt;
  logic [CW-1:0] lcnt;
  logic          de_d;
  logic          vs_d;
  logic          seen_fs;

  logic          line_end_c;
  logic          frame_start_c;
  logic [CW-1:0] lines_c;
  logic [3:0]    dith_c;
  logic [SW-1:0] r_sum_c;
  logic [SW-1:0] g_sum_c;
  logic [SW-1:0] b_sum_c;

  logic [RW-1:0] r_q;
  logic [GW-1:0] g_q;
  logic [RW-1:0] b_q;
  logic          de_q;
  logic          hs_q;
  logic          vs_q;

  // 4x4 ordered-dither threshold, row = line index, column = pixel index
  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] v;
    v = 4'd0;
    case ({y, x})
      4'h0: v = 4'd0;
      4'h1: v = 4'd8;
      4'h2: v = 4'd2;
      4'h3: v = 4'd10;
      4'h4: v = 4'd12;
      4'h5: v = 4'd4;
      4'h6: v = 4'd14;
      4'h7: v = 4'd6;
      4'h8: v = 4'd3;
      4'h9: v = 4'd11;
      4'hA: v = 4'd1;
      4'hB: v = 4'd9;
      4'hC: v = 4'd15;
      4'hD: v = 4'd7;
      4'hE: v = 4'd13;
      4'hF: v = 4'd5;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  // Event detection, line count including a line ending this cycle, dithered sums
  always_comb begin
    line_end_c    = de_d && !in_de;
    frame_start_c = (vs_d != VS_ACT) && (in_vs == VS_ACT);
    lines_c       = lcnt;
    if (line_end_c && (lcnt != CMAX)) begin
      lines_c = lcnt + CW'(1);
    end
    dith_c  = DITHER_EN ? bayer(lcnt[1:0], pcnt[1:0]) : 4'd0;
    r_sum_c = SW'(in_rgb[23:16]) + SW'(dith_c >> 1);
    g_sum_c = SW'(in_rgb[15:8])  + SW'(dith_c >> 2);
    b_sum_c = SW'(in_rgb[7:0])   + SW'(dith_c >> 1);
  end

  // Two-stage pixel pipeline: stage 1 holds the shifted sums, stage 2 saturates and gates
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      out_de  <= 1'b0;
      out_hs  <= 1'b1;
      out_vs  <= 1'b1;
      out_rgb <= '0;
    end else begin
      r_q     <= RW'(r_sum_c >> 3);
      g_q     <= GW'(g_sum_c >> 2);
      b_q     <= RW'(b_sum_c >> 3);
      de_q    <= in_de;
      hs_q    <= in_hs;
      vs_q    <= in_vs;
      out_de  <= de_q;
      out_hs  <= hs_q;
      out_vs  <= vs_q;
      out_rgb <= de_q ? {(r_q[5] ? 5'h1F : r_q[4:0]),
                         (g_q[6] ? 6'h3F : g_q[5:0]),
                         (b_q[5] ? 5'h1F : b_q[4:0])} : 16'h0000;
    end
  end

  // Geometry measurement; the first frame start after reset only aligns the line count
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      de_d      <= 1'b0;
      vs_d      <= 1'b1;
      seen_fs   <= 1'b0;
      pcnt      <= '0;
      lcnt      <= '0;
      line_px   <= '0;
      frame_ln  <= '0;
      frame_cnt <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      de_d <= in_de;
      vs_d <= in_vs;

      if (in_de) begin
        pcnt <= (pcnt == CMAX) ? CMAX : pcnt + CW'(1);
      end else begin
        pcnt <= '0;
      end

      if (line_end_c) begin
        line_px <= pcnt;
      end

      if (frame_start_c) begin
        lcnt    <= '0;
        seen_fs <= 1'b1;
        if (seen_fs) begin
          frame_ln  <= lines_c;
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        lcnt <= lines_c;
      end

      // A new error wins over a clear arriving in the same cycle
      if (line_end_c && (pcnt != CW'(PIX_W))) begin
        err_line <= 1'b1;
      end else if (err_clr) begin
        err_line <= 1'b0;
      end

      if (frame_start_c && seen_fs && (lines_c != CW'(PIX_H))) begin
        err_frame <= 1'b1;
      end else if (err_clr) begin
        err_frame <= 1'b0;
      end
    end
  end

endmodule
